// File: rtl/pkt_mem_rd_responder.sv
// pkt_mem_rd_responder
//
// Responder side of the BPF CPU packet-memory read interface. A read request
// is turned into one or two 32-bit BRAM word fetches. The big-endian field is
// then extracted and zero-extended, and returned with a one-cycle mem_vld. The
// block also terminates the acc/rej verdict strobes into a registered
// done/verdict pair for the buffer manager.
//
// Build option: define PKT_BOUNDS_CHECK_EN to enable the pkt_len bounds check.
// When enabled, a request whose last byte lies at or beyond pkt_len skips the
// BRAM and returns 0 with an oob pulse. When disabled, pkt_len is unused and
// oob is tied low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rd_en                 read request strobe (ignored while busy)
//   addr, transfer_sz     byte address and size (00 byte, 01 half, 1x word)
//   resp_data, mem_vld    zero-extended result and its one-cycle valid
//   busy                  read in flight
//   acc, rej              verdict strobes; either one aborts any in-flight read
//   done, verdict         one-cycle verdict pulse and held verdict (1 = accept)
//   pkt_len               packet length in bytes (bounds check)
//   oob                   out-of-bounds flag, pulses with mem_vld
//   bram_rd_en, bram_addr BRAM read port request (combinational)
//   bram_rdata            BRAM read data, one cycle after bram_rd_en

module pkt_mem_rd_responder #(
   parameter int unsigned BYTE_ADDR_WIDTH = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rd_en,
   input  logic [BYTE_ADDR_WIDTH-1:0] addr,
   input  logic [1:0]                 transfer_sz,
   output logic [31:0]                resp_data,
   output logic                       mem_vld,
   output logic                       busy,
   input  logic                       acc,
   input  logic                       rej,
   output logic                       done,
   output logic                       verdict,
   input  logic [BYTE_ADDR_WIDTH:0]   pkt_len,
   output logic                       oob,
   output logic                       bram_rd_en,
   output logic [BYTE_ADDR_WIDTH-3:0] bram_addr,
   input  logic [31:0]                bram_rdata
);

   localparam int unsigned WordAw = BYTE_ADDR_WIDTH - 2;

   typedef enum logic [1:0] {StIdle, StRd1, StRd2, StResp} state_e;

   state_e                     state_q, state_d;
   logic [BYTE_ADDR_WIDTH-1:0] addr_q;
   logic [1:0]                 sz_q;
   logic [31:0]                word_hi_q, word_lo_q;
   logic [31:0]                resp_data_q;
   logic                       mem_vld_q, done_q, verdict_q, oob_q;
   logic                       oob_pend_q;

   logic                       abort;
   logic                       capture;
   logic                       cap_oob;
   logic                       spans;
   logic [2:0]                 sz_bytes_q;
   logic [63:0]                window;
   logic [31:0]                field;

   // Size code to byte count; the reserved code reads a full word.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      unique case (sz)
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   assign abort      = acc | rej;
   assign capture    = (state_q == StIdle) & rd_en & ~abort;
   assign sz_bytes_q = size_bytes(sz_q);
   assign spans      = ({1'b0, addr_q[1:0]} + sz_bytes_q) > 3'd4;

`ifdef PKT_BOUNDS_CHECK_EN
   localparam int unsigned EndW = BYTE_ADDR_WIDTH + 1;
   logic [BYTE_ADDR_WIDTH:0] end_addr;

   // Last byte of the requested field, computed one bit wider so a field
   // running past the top of the buffer still compares against pkt_len.
   assign end_addr = {1'b0, addr} + EndW'(size_bytes(transfer_sz)) - EndW'(1);
   assign cap_oob  = end_addr >= pkt_len;
`else
   logic unused_pkt_len;

   assign unused_pkt_len = ^pkt_len;
   assign cap_oob        = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (capture) begin
                  state_d = cap_oob ? StResp : StRd1;
               end
            end
            StRd1:   state_d = spans ? StRd2 : StResp;
            StRd2:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs (BRAM request and busy)
   // ---------------------------------------------------------------------
   always_comb begin
      bram_rd_en = 1'b0;
      bram_addr  = '0;
      // Held quiet during reset and on the abort cycle so no stray fetch is
      // issued for a request that is being dropped.
      if (rst_n && !abort) begin
         unique case (state_q)
            StIdle: begin
               if (rd_en && !cap_oob) begin
                  bram_rd_en = 1'b1;
                  bram_addr  = addr[BYTE_ADDR_WIDTH-1:2];
               end
            end
            StRd1: begin
               if (spans) begin
                  bram_rd_en = 1'b1;
                  // Natural overflow wraps to word 0 at the buffer top.
                  bram_addr  = addr_q[BYTE_ADDR_WIDTH-1:2] + WordAw'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != StIdle);

   // ---------------------------------------------------------------------
   // Field extraction from the two-word big-endian window
   // ---------------------------------------------------------------------
   always_comb begin
      window = {word_hi_q, word_lo_q} << {addr_q[1:0], 3'b000};
      unique case (sz_q)
         2'b00:   field = {24'h0, window[63:56]};
         2'b01:   field = {16'h0, window[63:48]};
         default: field = window[63:32];
      endcase
   end

   // ---------------------------------------------------------------------
   // Request capture and word registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         sz_q       <= 2'b00;
         oob_pend_q <= 1'b0;
         word_hi_q  <= '0;
         word_lo_q  <= '0;
      end else begin
         if (capture) begin
            addr_q     <= addr;
            sz_q       <= transfer_sz;
            oob_pend_q <= cap_oob;
         end
         if (state_q == StRd1) begin
            word_hi_q <= bram_rdata;
         end
         if (state_q == StRd2) begin
            word_lo_q <= bram_rdata;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Response and verdict registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_data_q <= '0;
         mem_vld_q   <= 1'b0;
         oob_q       <= 1'b0;
         done_q      <= 1'b0;
         verdict_q   <= 1'b0;
      end else begin
         mem_vld_q <= (state_q == StResp) & ~abort;
         oob_q     <= (state_q == StResp) & ~abort & oob_pend_q;
         if ((state_q == StResp) && !abort) begin
            resp_data_q <= oob_pend_q ? 32'h0 : field;
         end
         done_q <= abort;
         if (abort) begin
            // Reject wins when both strobes arrive together.
            verdict_q <= acc & ~rej;
         end
      end
   end

   assign resp_data = resp_data_q;
   assign mem_vld   = mem_vld_q;
   assign oob       = oob_q;
   assign done      = done_q;
   assign verdict   = verdict_q;

endmodule

// File: doc/pkt_mem_rd_responder.md
Name: pkt_mem_rd_responder

Overview:
- Responder side of the BPF CPU's packet-memory read interface.
- Accepts the controller's read strobe with a byte address and transfer size, then fetches one or two 32-bit words from the packet buffer BRAM.
- Extracts and zero-extends the big-endian field and returns it with a single-cycle mem_vld.
- Also terminates the acc/rej verdict strobes, producing a registered done/verdict pair for the buffer manager.

Parameters:
- BYTE_ADDR_WIDTH, 12, width of the byte address into the packet buffer; BRAM word address is BYTE_ADDR_WIDTH-2 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read request strobe from the CPU controller
- addr  in  BYTE_ADDR_WIDTH  byte address of the field
- transfer_sz  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- resp_data  out  32  zero-extended read result
- mem_vld  out  1  one-cycle pulse: resp_data valid
- busy  out  1  read in progress; rd_en ignored while high
- acc  in  1  accept strobe from controller
- rej  in  1  reject strobe from controller
- done  out  1  one-cycle pulse: verdict issued
- verdict  out  1  1 accept, 0 reject; held until the next done
- pkt_len  in  BYTE_ADDR_WIDTH+1  packet length in bytes (bounds check)
- oob  out  1  one-cycle pulse with mem_vld when the read exceeded pkt_len
- bram_rd_en  out  1  BRAM read enable
- bram_addr  out  BYTE_ADDR_WIDTH-2  BRAM word address
- bram_rdata  in  32  BRAM data, valid one cycle after bram_rd_en

Behaviour:
- Reset (async, rst_n low) clears all registered outputs: resp_data=0, mem_vld=0, busy=0, done=0, verdict=0, oob=0. FSM goes to IDLE.
- bram_rd_en and bram_addr are combinational from the FSM and request; they are 0 in reset.
- Byte order is big-endian: the lowest address byte is the MSB of the word, bytes packed in bram_rdata[31:24] down to [7:0].
- Field end = addr + size - 1, with size 1/2/4.
- A read spans two words when addr[1:0] + size > 4.
- FSM states: IDLE, RD1, RD2, RESP.
- IDLE:
  - rd_en=1 captures addr and transfer_sz.
  - Drives bram_rd_en=1 with bram_addr=addr[MSB:2] in the same cycle, then goes to RD1.
  - busy=1 from the next cycle.
- RD1:
  - Latches bram_rdata into word_hi.
  - If the read spans two words, issues the read for word address +1 (wraps modulo buffer size) and goes to RD2.
  - Otherwise goes to RESP.
- RD2: latches bram_rdata into word_lo and goes to RESP.
- RESP:
  - Extracts the field from the {word_hi, word_lo} 64-bit window at offset addr[1:0].
  - Registers resp_data and pulses mem_vld, then goes to IDLE (busy=0 the same cycle mem_vld is high).
- Latency (rd_en at cycle T): single-word mem_vld at T+3; spanning mem_vld at T+4.
- rd_en while busy: ignored, no effect on the in-flight read.
- acc/rej:
  - Sampled every cycle.
  - If either is high, done pulses next cycle and verdict = acc & ~rej, so rej wins on a tie.
  - Any in-flight read is aborted: FSM returns to IDLE and no mem_vld is issued.
  - rd_en in the same cycle as acc/rej is dropped.
- Reset mid-read: everything clears immediately; no mem_vld follows.

Optional Feature:
- Macro PKT_BOUNDS_CHECK_EN.
- When defined:
  - At capture, if end >= pkt_len, no BRAM read is issued.
  - FSM goes directly to RESP; resp_data=0, mem_vld and oob pulse at T+2.
- When undefined:
  - pkt_len is unused and oob is tied to 0.
  - Out-of-range reads return whatever the BRAM holds, wrapping modulo buffer size.

Test Plan:
- BRAM word0=0x00112233, word1=0x44556677. Byte read at addr 2 → resp_data=0x00000022, mem_vld at T+3, one bram_rd_en.
- Halfword at addr 3 → two BRAM reads (word addrs 0, 1), resp_data=0x00003344 at T+4.
- Word at addr 1 → 0x11223344 at T+4. Word at addr 4 → 0x44556677 at T+3. Back-to-back requests: rd_en pulsed while busy is ignored.
- PKT_BOUNDS_CHECK_EN defined, pkt_len=6: word at addr 4 → mem_vld and oob at T+2, resp_data=0, no bram_rd_en. Halfword at addr 4 → 0x00004455, oob=0.
- acc=1 and rej=1 in the same cycle → done pulse next cycle, verdict=0. acc alone → verdict=1. acc during RD2 of a spanning read → no mem_vld, FSM back in IDLE.
- rst_n asserted low during RD1 → busy=0 and outputs clear asynchronously. After release, a new byte read at addr 0 → 0x00000000 with correct T+3 timing.
